// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-address constants and PC sequencer state encodings.
// The address map is shared with CP0 and the instruction memory.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFF;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

endpackage

// File: rtl/pc_adder.sv
// 32-bit modulo adder producing a + NUM; wraps silently on overflow.
module pc_adder #(
    parameter logic [31:0] NUM = 32'd4
) (
    input  logic [31:0] a,
    output logic [31:0] sum
);

    assign sum = a + NUM;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks the next PC each cycle and parks a branch/jump
// redirect that arrives while IF is stalled until the stall clears.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = pc_sequencer_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = pc_sequencer_pkg::EXC_VECTOR,
    parameter logic [31:0] IM_BASE    = pc_sequencer_pkg::IM_BASE,
    parameter logic [31:0] IM_LIMIT   = pc_sequencer_pkg::IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        adel,
    output logic        redirect_pending
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] pend_q,  pend_d;
    logic [0:0]  state_q, state_d;
    logic [31:0] redirect_target;

    pc_adder #(.NUM(32'd4)) u_pc_adder (
        .a   (pc_q),
        .sum (pc_plus4)
    );

    // Jump outranks a taken branch whenever both are presented together.
    assign redirect_target = jump ? jump_target : br_target;

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        state_d = state_q;
        if (exc_req) begin
            pc_d    = EXC_VECTOR;
            state_d = ST_RUN;
        end else if (eret) begin
            pc_d    = epc;
            state_d = ST_RUN;
        end else if (state_q == ST_PEND) begin
            // Requests seen here are the same frozen instruction; ignore them.
            if (!stall) begin
                pc_d    = pend_q;
                state_d = ST_RUN;
            end
        end else if (!stall) begin
            if (jump || br_taken) begin
                pc_d = redirect_target;
            end else begin
                pc_d = pc_plus4;
            end
        end else if (jump || br_taken) begin
            pend_d  = redirect_target;
            state_d = ST_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = (state_q == ST_PEND);
    assign adel             = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

endmodule
